mlb_row_writer: RTL and testbench
=================================

# mlb_row_writer

Write-side controller for the multiple-level buffer (MLB). It accepts a stream of 32-bit words on a valid/ready port and packs each group of 16 consecutive words into one 16-lane row. It then drives the MLB write port (`write_en`, `sel_pe`, `in0..in15`) once per row, starting at a programmable row and wrapping modulo 32. It sits between the memory-fetch path and the MLB, and yields to the MLB reader, because the MLB gives read priority over write.

## Interface
Parameters:
- DATA_W, 32, width of one word / one MLB lane
- LANES, 16, words per MLB row
- ROWS, 32, MLB rows (sel_pe range)
- ROW_W, 5, log2(ROWS)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a fill job; ignored unless idle
- base_row  in  ROW_W  first MLB row to write; sampled on accepted start
- num_rows  in  ROW_W+1  rows to write; sampled on accepted start; 0 is legal; values >32 are clamped to 32
- s_valid  in  1  stream word valid
- s_data  in  DATA_W  stream word
- s_ready  out  1  stream word accepted when s_valid && s_ready
- mlb_rd_busy  in  1  reader currently owns the MLB port; write is stalled while high
- mlb_write_en  out  1  to MLB write_en
- mlb_read_en  out  1  to MLB read_en; constant 0
- mlb_sel_pe  out  ROW_W  to MLB sel_pe
- mlb_wdata  out  LANES*DATA_W  lane k = bits [k*DATA_W +: DATA_W], maps to MLB in k
- busy  out  1  job in progress (FILL or WRITE)
- done  out  1  one-cycle pulse at job end

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- **IDLE**
  - start with num_rows ≠ 0: latch row_ptr = base_row and rows_left = min(num_rows, 32), clear lane_cnt, go to FILL.
  - start with num_rows = 0: go to DONE.
- **FILL**
  - s_ready = 1.
  - Each handshake stores s_data into lane lane_cnt of the pack register and increments lane_cnt.
  - The handshake on lane 15 goes to WRITE and clears lane_cnt.
  - Words arrive in lane order 0..15. No lane is skipped, and partial rows are never written.
- **WRITE**
  - s_ready = 0.
  - If mlb_rd_busy = 1: mlb_write_en = 0 and the FSM stays in WRITE.
  - Otherwise: mlb_write_en = 1 for exactly one cycle, with mlb_sel_pe = row_ptr and mlb_wdata = the packed row. Then row_ptr increments (31 wraps to 0) and rows_left decrements.
  - rows_left reaching 0 goes to DONE; otherwise the FSM returns to FILL.
- **DONE**: done = 1 for one cycle, then IDLE. A start in this cycle is ignored.
- mlb_read_en is held at 0 at all times.
- mlb_sel_pe always shows row_ptr.
- mlb_wdata holds its contents between writes. It is only updated by FILL handshakes.
- Reset mid-job:
  - Returns to IDLE, discards any partial row, and zeroes all outputs.
  - MLB contents are unaffected because no write_en is generated.

## Timing
- Reset values:
  - mlb_write_en, mlb_read_en, s_ready, busy, done = 0.
  - mlb_sel_pe = 0, mlb_wdata = 0.
  - FSM = IDLE, counters = 0.
- start accepted at cycle 0 → FILL, with s_ready = 1 from cycle 1.
- Last (16th) handshake at cycle t → mlb_write_en = 1 at cycle t+1, provided mlb_rd_busy = 0 at t+1 → s_ready = 1 again at t+2.
- The best-case throughput is 16 words per 17 cycles.
- A final write at cycle w is followed by done = 1 at w+1 and busy = 0 from w+1.
- num_rows = 0: start at cycle 0 gives done at cycle 1 with no write.
- mlb_rd_busy is sampled combinationally in WRITE. Each cycle it is high delays the write by one cycle.
- s_valid may toggle freely. A low s_valid simply stalls FILL.

## Structure
- Shared package `mlb_pkg`:
  - DATA_W, LANES, ROWS, ROW_W constants.
  - FSM state enum.
  - The MLB port bundle width (LANES*DATA_W); the MLB and its reader use the same constants.
- One natural sub-module, `mlb_row_packer`:
  - Contains the lane counter and the LANES×DATA_W pack register.
  - Inputs: load strobe, word, clear.
  - Outputs: row_full pulse and the packed row.
  - The FSM, row_ptr and rows_left stay in the top level.

## Test plan
- Reset mid-FILL:
  - rst high after 7 words → all outputs 0 next cycle, and no mlb_write_en.
  - A new job then writes its first row with lanes 0..15 = the new stream, with no stale data.
- base_row = 3, num_rows = 1, words 0x100..0x10F streamed with s_valid always high → one write: sel_pe = 3, lane k = 0x100+k, 1 cycle after the 16th handshake; done one cycle later.
- base_row = 30, num_rows = 4, words 0..63 → writes in row order 30, 31, 0, 1 (wrap), each row holding words 16r..16r+15; exactly 4 write_en pulses; done after the 4th.
- mlb_rd_busy held high 5 cycles when the row is ready → write_en stays 0 and s_ready stays 0 for those 5 cycles; write occurs in the cycle busy drops, with data unchanged.
- num_rows = 0 → done at cycle 1, s_ready never 1. num_rows = 40 → exactly 32 writes.
- start pulsed during FILL and in the DONE cycle → ignored: row count and base_row unchanged. s_valid toggling 1/0 → packing order preserved.

Source files
------------

// File: rtl/mlb_pkg.sv
// rtl/mlb_pkg.sv - shared MLB geometry constants and row-writer FSM state type
//
// Constants shared by the MLB, its reader and its writer so all three agree
// on row width and row count. No ports.

package mlb_pkg;

    localparam int DATA_W   = 32;              // one word / one MLB lane
    localparam int LANES    = 16;              // words per MLB row
    localparam int ROWS     = 32;              // MLB rows (sel_pe range)
    localparam int ROW_W    = 5;               // log2(ROWS)
    localparam int ROW_BITS = LANES * DATA_W;  // MLB port bundle width

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } wr_state_t;

endpackage

// File: rtl/mlb_row_packer.sv
// rtl/mlb_row_packer.sv - lane counter and pack register for one MLB row
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       store word into the current lane and advance the lane counter
//   clear      restart at lane 0 (pack register contents are kept)
//   word       incoming word
//   row_full   high in the cycle the last lane is loaded
//   row        packed row, lane k = row[k*DATA_W +: DATA_W]

module mlb_row_packer
    import mlb_pkg::*;
#(
    parameter int DATA_W = mlb_pkg::DATA_W,
    parameter int LANES  = mlb_pkg::LANES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      clear,
    input  logic [DATA_W-1:0]         word,
    output logic                      row_full,
    output logic [LANES*DATA_W-1:0]   row
);

    localparam int LANE_W = $clog2(LANES);

    logic [LANE_W-1:0] lane_cnt;

    assign row_full = load && (lane_cnt == LANE_W'(LANES - 1));

    // The register only changes on a load, so the row stays stable on the
    // MLB data pins for as long as the write is held off by the reader.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt <= '0;
            row      <= '0;
        end else if (clear) begin
            lane_cnt <= '0;
        end else if (load) begin
            row[lane_cnt*DATA_W +: DATA_W] <= word;
            lane_cnt <= row_full ? '0 : lane_cnt + LANE_W'(1);
        end
    end

endmodule

// File: rtl/mlb_row_writer.sv
// rtl/mlb_row_writer.sv - packs a word stream into 16-lane rows and writes them to the MLB
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, base_row,         begin a fill job of num_rows rows at base_row
//   num_rows                 (num_rows 0 ends at once, >ROWS is clamped)
//   s_valid, s_data, s_ready word stream in
//   mlb_rd_busy              reader owns the MLB port; writes wait
//   mlb_write_en, mlb_read_en, mlb_sel_pe, mlb_wdata   MLB write port
//   busy                     job in progress (FILL or WRITE)
//   done                     one-cycle pulse at job end

module mlb_row_writer
    import mlb_pkg::*;
#(
    parameter int DATA_W = mlb_pkg::DATA_W,
    parameter int LANES  = mlb_pkg::LANES,
    parameter int ROWS   = mlb_pkg::ROWS,
    parameter int ROW_W  = mlb_pkg::ROW_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ROW_W-1:0]          base_row,
    input  logic [ROW_W:0]            num_rows,
    input  logic                      s_valid,
    input  logic [DATA_W-1:0]         s_data,
    output logic                      s_ready,
    input  logic                      mlb_rd_busy,
    output logic                      mlb_write_en,
    output logic                      mlb_read_en,
    output logic [ROW_W-1:0]          mlb_sel_pe,
    output logic [LANES*DATA_W-1:0]   mlb_wdata,
    output logic                      busy,
    output logic                      done
);

    wr_state_t        state;
    logic [ROW_W-1:0] row_ptr;
    logic [ROW_W:0]   rows_left;
    logic [ROW_W:0]   rows_clamped;

    logic             pack_load;
    logic             pack_clear;
    logic             row_full;

    assign rows_clamped = (num_rows > (ROW_W+1)'(ROWS)) ? (ROW_W+1)'(ROWS) : num_rows;

    assign pack_load  = (state == ST_FILL) && s_valid;
    assign pack_clear = (state == ST_IDLE) && start;

    mlb_row_packer #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .load     (pack_load),
        .clear    (pack_clear),
        .word     (s_data),
        .row_full (row_full),
        .row      (mlb_wdata)
    );

    // The reader has priority on the shared MLB port, so the write strobe
    // follows mlb_rd_busy combinationally rather than waiting a cycle.
    assign mlb_write_en = (state == ST_WRITE) && !mlb_rd_busy;
    assign mlb_read_en  = 1'b0;
    assign mlb_sel_pe   = row_ptr;
    assign s_ready      = (state == ST_FILL);
    assign busy         = (state == ST_FILL) || (state == ST_WRITE);
    assign done         = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            row_ptr   <= '0;
            rows_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_rows == '0) begin
                            state <= ST_DONE;
                        end else begin
                            row_ptr   <= base_row;
                            rows_left <= rows_clamped;
                            state     <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (row_full) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!mlb_rd_busy) begin
                        // ROWS is a power of two, so the add wraps 31 -> 0.
                        row_ptr   <= row_ptr + ROW_W'(1);
                        rows_left <= rows_left - (ROW_W+1)'(1);
                        state     <= (rows_left == (ROW_W+1)'(1)) ? ST_DONE : ST_FILL;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlb_row_writer.sv
// tb/tb_mlb_row_writer.sv - scoreboard bench for mlb_row_writer

module tb_mlb_row_writer;

    logic         clk;
    logic         rst;
    logic         start;
    logic [4:0]   base_row;
    logic [5:0]   num_rows;
    logic         s_valid;
    logic [31:0]  s_data;
    logic         s_ready;
    logic         mlb_rd_busy;
    logic         mlb_write_en;
    logic         mlb_read_en;
    logic [4:0]   mlb_sel_pe;
    logic [511:0] mlb_wdata;
    logic         busy;
    logic         done;

    typedef struct {
        logic [4:0]   sel;
        logic [511:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    mlb_row_writer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_row     (base_row),
        .num_rows     (num_rows),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .mlb_rd_busy  (mlb_rd_busy),
        .mlb_write_en (mlb_write_en),
        .mlb_read_en  (mlb_read_en),
        .mlb_sel_pe   (mlb_sel_pe),
        .mlb_wdata    (mlb_wdata),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every MLB write must match the next expected row.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && mlb_write_en) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write act sel=%0d req=no write", mlb_sel_pe);
                end else begin
                    e = exp_q.pop_front();
                    if (mlb_sel_pe !== e.sel || mlb_wdata !== e.data || mlb_read_en !== 1'b0) begin
                        n_err++;
                        $display("FAIL write_row act sel=%0d rd=%0b data=%h req sel=%0d data=%h",
                                 mlb_sel_pe, mlb_read_en, mlb_wdata, e.sel, e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    function automatic logic [511:0] mk_row(input logic [31:0] first);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = first + 32'(k);
        return r;
    endfunction

    task automatic start_job(input logic [4:0] b, input logic [5:0] n);
        start = 1'b1; base_row = b; num_rows = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input bit gap);
        int t = 0;
        s_valid = 1'b1; s_data = w;
        @(negedge clk);
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            chk("handshake_timeout", 64'(s_ready), 64'd1);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_rows(input logic [4:0] b, input int nrows, input logic [31:0] w0, input bit gap);
        wr_t e;
        for (int r = 0; r < nrows; r++) begin
            e.sel  = b + 5'(r);
            e.data = mk_row(w0 + 32'(16 * r));
            exp_q.push_back(e);
            for (int k = 0; k < 16; k++) push_word(w0 + 32'(16 * r + k), gap);
        end
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        @(negedge clk);
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    initial begin
        wr_t e;
        rst = 1'b1; start = 1'b0; base_row = '0; num_rows = '0;
        s_valid = 1'b0; s_data = '0; mlb_rd_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {58'd0, mlb_write_en, mlb_read_en, s_ready, busy, done, 1'b0}, 64'd0);
        chk("reset_sel", 64'(mlb_sel_pe), 64'd0);
        chk("reset_wdata_nz", 64'(|mlb_wdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single row at row 3, exact latency to write and done.
        start_job(5'd3, 6'd1);
        e.sel = 5'd3; e.data = mk_row(32'h100); exp_q.push_back(e);
        for (int k = 0; k < 16; k++) push_word(32'h100 + 32'(k), 1'b0);
        @(negedge clk);
        chk("t1_write_latency", 64'(mlb_write_en), 64'd1);
        @(negedge clk);
        chk("t1_done", {62'd0, done, busy}, 64'b10);

        // Four rows from row 30, wrapping to 0 and 1.
        @(posedge clk); #1;
        start_job(5'd30, 6'd4);
        run_rows(5'd30, 4, 32'h0, 1'b0);
        wait_done("t2_done");
        chk("t2_all_written", 64'(exp_q.size()), 64'd0);

        // Reset after 7 words: outputs clear, partial row never written.
        @(posedge clk); #1;
        start_job(5'd5, 6'd1);
        for (int k = 0; k < 7; k++) push_word(32'hDEAD0000 + 32'(k), 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", {58'd0, mlb_write_en, mlb_read_en, s_ready, busy, done, 1'b0}, 64'd0);
        chk("rst_mid_sel", 64'(mlb_sel_pe), 64'd0);
        chk("rst_mid_wdata_nz", 64'(|mlb_wdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_job(5'd7, 6'd1);
        run_rows(5'd7, 1, 32'hA00, 1'b0);
        wait_done("rst_new_job_done");

        // Reader holds the port for 5 cycles once the row is full.
        @(posedge clk); #1;
        start_job(5'd10, 6'd1);
        mlb_rd_busy = 1'b1;
        e.sel = 5'd10; e.data = mk_row(32'h200); exp_q.push_back(e);
        for (int k = 0; k < 16; k++) push_word(32'h200 + 32'(k), 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_we_rdy", {62'd0, mlb_write_en, s_ready}, 64'd0);
            @(posedge clk); #1;
        end
        mlb_rd_busy = 1'b0;
        @(negedge clk);
        chk("stall_release_we", 64'(mlb_write_en), 64'd1);
        wait_done("stall_done");

        // num_rows = 0: done in cycle 1, never ready.
        @(posedge clk); #1;
        start_job(5'd4, 6'd0);
        @(negedge clk);
        chk("zero_done_rdy", {62'd0, done, s_ready}, 64'b10);
        @(negedge clk);
        chk("zero_done_once", {62'd0, done, s_ready}, 64'd0);

        // num_rows = 40 clamps to 32 rows.
        @(posedge clk); #1;
        start_job(5'd0, 6'd40);
        run_rows(5'd0, 32, 32'h1000, 1'b0);
        wait_done("clamp_done");
        chk("clamp_all_written", 64'(exp_q.size()), 64'd0);

        // Start ignored in FILL and DONE; s_valid toggling keeps lane order.
        @(posedge clk); #1;
        start_job(5'd2, 6'd2);
        e.sel = 5'd2; e.data = mk_row(32'h300); exp_q.push_back(e);
        for (int k = 0; k < 5; k++) push_word(32'h300 + 32'(k), 1'b1);
        start = 1'b1; base_row = 5'd20; num_rows = 6'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 5; k < 16; k++) push_word(32'h300 + 32'(k), 1'b1);
        run_rows(5'd3, 1, 32'h310, 1'b1);
        wait_done("ign_done");
        start = 1'b1; base_row = 5'd9; num_rows = 6'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("ign_done_start", {62'd0, busy, s_ready}, 64'd0);
        chk("ign_all_written", 64'(exp_q.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
